rotated_sprite_mapper: RTL and testbench

Pipelined, parametrised successor to the single-object color mapper. It renders up to N_OBJ independently rotated objects per pixel. Each object is a square or a circle with its own centre, half-size, 2x2 fixed-point rotation matrix and colour. Lower-indexed objects take priority, and a horizontal grey gradient fills the background. It sits between the VGA/HDMI timing generator (DrawX/DrawY) and the HDMI encoder. Object parameters are written through a shadow-register port and committed atomically at frame start.

---
 rtl/render_pkg.sv | 53 +++++
 rtl/shape_hit_unit.sv | 85 ++++++++
 rtl/rotated_sprite_mapper.sv | 149 ++++++++++++++
 tb/tb_rotated_sprite_mapper.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : render_pkg
//  Description : Shared types and constants for the rotated sprite renderer.
//                It holds the object descriptor (obj_t), the fixed-point
//                matrix types, the shadow-port field codes and the shape
//                modes.
//  Revision    : 1.0 - initial release
// ============================================================================
package render_pkg;

  localparam int COORD_W = 10;  // default pixel coordinate width
  localparam int FRAC    = 6;   // default fractional bits of matrix entries

  typedef logic signed [15:0] fix_t;           // signed Q(15-FRAC).FRAC
  typedef fix_t [1:0][1:0]    mat2_t;          // m[row][col]

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] size;
    mat2_t              m;
    logic               enable;
    logic               mode;
    logic [11:0]        color;                 // {R,G,B}
  } obj_t;

  // Field codes for the shadow write port
  localparam logic [2:0] FLD_X    = 3'd0;
  localparam logic [2:0] FLD_Y    = 3'd1;
  localparam logic [2:0] FLD_SIZE = 3'd2;
  localparam logic [2:0] FLD_M00  = 3'd3;
  localparam logic [2:0] FLD_M01  = 3'd4;
  localparam logic [2:0] FLD_M10  = 3'd5;
  localparam logic [2:0] FLD_M11  = 3'd6;
  localparam logic [2:0] FLD_ATTR = 3'd7;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_CIRCLE = 1'b1;

  localparam fix_t FIX_ONE = fix_t'(1 << FRAC);

  // Power-up descriptor: disabled object carrying the identity matrix
  function automatic obj_t obj_reset();
    obj_t o;
    o         = '0;
    o.m[0][0] = FIX_ONE;
    o.m[1][1] = FIX_ONE;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shape_hit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shape_hit_unit
//  Description : Stages S1-S3 for a single object. It computes the offset
//                from the object centre, rotates the offset into object
//                space and tests it against a square or circle outline.
//  Ports       : clk_i/rst_i     - pixel clock, synchronous active-high reset
//                draw_x_i/_y_i   - current pixel coordinate
//                obj_i           - active descriptor of this object
//                hit_o/color_o   - registered in-shape flag and colour (S3)
//  Revision    : 1.0 - initial release
// ============================================================================
module shape_hit_unit #(
  parameter int COORD_W = 10,
  parameter int FRAC    = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  input  render_pkg::obj_t   obj_i,
  output logic               hit_o,
  output logic [11:0]        color_o
);
  import render_pkg::*;

  localparam int DW = COORD_W + 1;   // centre offset width
  localparam int RW = COORD_W + 2;   // rotated coordinate width
  localparam int SW = 16 + DW + 1;   // dot-product width, no overflow
  localparam int QW = 2 * RW + 1;    // sum of squares width, no overflow

  logic signed [DW-1:0] dx_d, dy_d, dx_q, dy_q;
  logic signed [SW-1:0] su_w, sv_w;
  logic signed [RW-1:0] u_d, v_d, u_q, v_q;
  logic [RW-1:0]        au_w, av_w;
  logic [QW-1:0]        uu_w, vv_w, ss_w;
  logic                 in_sq_w, in_circ_w, hit_d, hit_q;
  logic [11:0]          color_q;

  // S1: offset from centre, both operands zero-extended so the sign is exact
  assign dx_d = $signed({1'b0, draw_x_i}) - $signed({1'b0, obj_i.x});
  assign dy_d = $signed({1'b0, draw_y_i}) - $signed({1'b0, obj_i.y});

  // S2: full-precision rotation, floor via arithmetic shift, then truncate
  assign su_w = SW'($signed(obj_i.m[0][0])) * SW'(dx_q)
              + SW'($signed(obj_i.m[0][1])) * SW'(dy_q);
  assign sv_w = SW'($signed(obj_i.m[1][0])) * SW'(dx_q)
              + SW'($signed(obj_i.m[1][1])) * SW'(dy_q);
  assign u_d  = RW'(su_w >>> FRAC);
  assign v_d  = RW'(sv_w >>> FRAC);

  // S3: magnitudes are unsigned, so the most negative value maps correctly
  assign au_w      = u_q[RW-1] ? $unsigned(-u_q) : $unsigned(u_q);
  assign av_w      = v_q[RW-1] ? $unsigned(-v_q) : $unsigned(v_q);
  assign uu_w      = QW'(au_w) * QW'(au_w);
  assign vv_w      = QW'(av_w) * QW'(av_w);
  assign ss_w      = QW'(obj_i.size) * QW'(obj_i.size);
  assign in_sq_w   = (au_w <= RW'(obj_i.size)) && (av_w <= RW'(obj_i.size));
  assign in_circ_w = (uu_w + vv_w) <= ss_w;
  assign hit_d     = obj_i.enable &&
                     ((obj_i.mode == MODE_CIRCLE) ? in_circ_w : in_sq_w);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dx_q    <= '0;
      dy_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
      hit_q   <= 1'b0;
      color_q <= '0;
    end else begin
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      u_q     <= u_d;
      v_q     <= v_d;
      hit_q   <= hit_d;
      color_q <= obj_i.color;
    end
  end

  assign hit_o   = hit_q;
  assign color_o = color_q;

endmodule
`default_nettype wire

// File: rtl/rotated_sprite_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : rotated_sprite_mapper
//  Description : Renders N_OBJ rotated squares/circles over a horizontal grey
//                gradient. Object parameters are written to shadow registers
//                and committed to the active set on frame_start. Four-stage
//                pipeline with one pixel per clock.
//  Ports       : Clk/Reset                 - pixel clock, sync active-high reset
//                in_valid/DrawX/DrawY      - pixel from the timing generator
//                frame_start               - shadow -> active commit pulse
//                obj_we/sel/field/wdata    - shadow register write port
//                out_valid/hit/hit_id/RGB  - rendered pixel, latency 4
//  Revision    : 1.0 - initial release
// ============================================================================
module rotated_sprite_mapper #(
  parameter int N_OBJ   = 4,
  parameter int COORD_W = 10,
  parameter int FRAC    = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               frame_start,
  input  logic               obj_we,
  input  logic [2:0]         obj_sel,
  input  logic [2:0]         obj_field,
  input  logic [15:0]        obj_wdata,
  output logic               out_valid,
  output logic               hit,
  output logic [2:0]         hit_id,
  output logic [3:0]         Red,
  output logic [3:0]         Green,
  output logic [3:0]         Blue
);
  import render_pkg::*;

  obj_t         shadow_q [N_OBJ];
  obj_t         active_q [N_OBJ];
  logic [N_OBJ-1:0] obj_hit_w;
  logic [11:0]  obj_color_w [N_OBJ];

  logic         v1_q, v2_q, v3_q, out_valid_q;
  logic [3:0]   gx1_q, gx2_q, gx3_q;    // DrawX[9:6] travelling with the pixel
  logic         hit_d, hit_q;
  logic [2:0]   hit_id_d, hit_id_q;
  logic [11:0]  rgb_d, rgb_q;

  // Register file. Commit copies the pre-edge shadow, so a write landing in
  // the same cycle only reaches the active set on the following commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_OBJ; i++) begin
        shadow_q[i] <= obj_reset();
        active_q[i] <= obj_reset();
      end
    end else begin
      if (frame_start) begin
        active_q <= shadow_q;
      end
      for (int i = 0; i < N_OBJ; i++) begin
        if (obj_we && obj_sel == 3'(i)) begin
          case (obj_field)
            FLD_X:    shadow_q[i].x       <= obj_wdata[COORD_W-1:0];
            FLD_Y:    shadow_q[i].y       <= obj_wdata[COORD_W-1:0];
            FLD_SIZE: shadow_q[i].size    <= obj_wdata[COORD_W-1:0];
            FLD_M00:  shadow_q[i].m[0][0] <= obj_wdata;
            FLD_M01:  shadow_q[i].m[0][1] <= obj_wdata;
            FLD_M10:  shadow_q[i].m[1][0] <= obj_wdata;
            FLD_M11:  shadow_q[i].m[1][1] <= obj_wdata;
            FLD_ATTR: begin
              shadow_q[i].enable <= obj_wdata[15];
              shadow_q[i].mode   <= obj_wdata[14];
              shadow_q[i].color  <= obj_wdata[11:0];
            end
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    shape_hit_unit #(
      .COORD_W (COORD_W),
      .FRAC    (FRAC)
    ) u_unit (
      .clk_i    (Clk),
      .rst_i    (Reset),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .obj_i    (active_q[g]),
      .hit_o    (obj_hit_w[g]),
      .color_o  (obj_color_w[g])
    );
  end

  // S4: scan from the highest index down so the lowest index wins
  always_comb begin
    hit_d    = 1'b0;
    hit_id_d = '0;
    rgb_d    = {3{4'hf - gx3_q}};
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (obj_hit_w[i]) begin
        hit_d    = 1'b1;
        hit_id_d = 3'(i);
        rgb_d    = obj_color_w[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      gx1_q       <= '0;
      gx2_q       <= '0;
      gx3_q       <= '0;
      hit_q       <= 1'b0;
      hit_id_q    <= '0;
      rgb_q       <= '0;
    end else begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      gx1_q       <= DrawX[9:6];
      gx2_q       <= gx1_q;
      gx3_q       <= gx2_q;
      // Bubbles leave the visible outputs untouched
      if (v3_q) begin
        hit_q    <= hit_d;
        hit_id_q <= hit_id_d;
        rgb_q    <= rgb_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign hit_id    = hit_id_q;
  assign Red       = rgb_q[11:8];
  assign Green     = rgb_q[7:4];
  assign Blue      = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_rotated_sprite_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotated_sprite_mapper
//  Description : Scoreboard bench for rotated_sprite_mapper. Stimulus pushes
//                hand-computed expectations; a negedge monitor pops them
//                whenever out_valid is seen and also checks output hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotated_sprite_mapper;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        frame_start = 1'b0;
  logic        obj_we = 1'b0;
  logic [2:0]  obj_sel = '0;
  logic [2:0]  obj_field = '0;
  logic [15:0] obj_wdata = '0;
  logic        out_valid, hit;
  logic [2:0]  hit_id;
  logic [3:0]  Red, Green, Blue;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        hit;
    logic [2:0]  id;
    int          t;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] last = '0;   // {hit, hit_id, RGB} of the last valid output

  rotated_sprite_mapper #(
    .N_OBJ   (4),
    .COORD_W (10),
    .FRAC    (6)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .obj_we      (obj_we),
    .obj_sel     (obj_sel),
    .obj_field   (obj_field),
    .obj_wdata   (obj_wdata),
    .out_valid   (out_valid),
    .hit         (hit),
    .hit_id      (hit_id),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge Clk) begin
    if (Reset) begin
      last = '0;
    end else if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got hit=%b id=%0d rgb=%h, required no output",
                 hit, hit_id, {Red, Green, Blue});
      end else begin
        e = sb.pop_front();
        if ({hit, hit_id, Red, Green, Blue} !== {e.hit, e.id, e.rgb} || (cyc - e.t) != 4) begin
          errors++;
          $display("FAIL pixel_issued_cyc%0d: got hit=%b id=%0d rgb=%h lat=%0d, required hit=%b id=%0d rgb=%h lat=4",
                   e.t, hit, hit_id, {Red, Green, Blue}, cyc - e.t, e.hit, e.id, e.rgb);
        end
      end
      last = {hit, hit_id, Red, Green, Blue};
    end else begin
      checks++;
      if ({hit, hit_id, Red, Green, Blue} !== last) begin
        errors++;
        $display("FAIL hold_on_bubble: got %h, required %h", {hit, hit_id, Red, Green, Blue}, last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] rgb,
                     input logic h, input logic [2:0] id);
    in_valid = 1'b1;
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    sb.push_back('{rgb: rgb, hit: h, id: id, t: cyc});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wr(input int sel, input int fld, input logic [15:0] d, input logic fs);
    obj_we      = 1'b1;
    obj_sel     = 3'(sel);
    obj_field   = 3'(fld);
    obj_wdata   = d;
    frame_start = fs;
    tick();
    obj_we      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    @(negedge Clk);
    checks++;
    if ({out_valid, hit, hit_id, Red, Green, Blue} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {out_valid, hit, hit_id, Red, Green, Blue});
    end
    tick();
    Reset = 1'b0;
    tick();

    // Background only
    pix(0, 0, 12'hFFF, 1'b0, 3'd0);
    pix(320, 0, 12'hAAA, 1'b0, 3'd0);
    idle(6);

    // Identity square, obj0 at (320,240) size 10 colour AF3
    wr(0, 0, 16'd320, 1'b0);
    wr(0, 1, 16'd240, 1'b0);
    wr(0, 2, 16'd10, 1'b0);
    wr(0, 7, 16'h8AF3, 1'b0);
    commit();
    pix(330, 240, 12'hAF3, 1'b1, 3'd0);
    pix(331, 240, 12'hAAA, 1'b0, 3'd0);
    pix(309, 250, 12'hBBB, 1'b0, 3'd0);
    pix(320, 230, 12'hAF3, 1'b1, 3'd0);
    idle(6);

    // Rotated square: m = [45 -45; 45 45]
    wr(0, 3, 16'd45, 1'b0);
    wr(0, 4, 16'hFFD3, 1'b0);
    wr(0, 5, 16'd45, 1'b0);
    wr(0, 6, 16'd45, 1'b0);
    commit();
    pix(334, 240, 12'hAF3, 1'b1, 3'd0);  // u=v=9
    pix(330, 250, 12'hAAA, 1'b0, 3'd0);  // u=0 v=14
    pix(310, 240, 12'hAF3, 1'b1, 3'd0);  // u=v=-8
    pix(335, 240, 12'hAF3, 1'b1, 3'd0);  // u=v=10
    pix(336, 240, 12'hAAA, 1'b0, 3'd0);  // u=v=11
    pix(306, 240, 12'hAF3, 1'b1, 3'd0);  // -630>>>6 = -10
    pix(305, 240, 12'hBBB, 1'b0, 3'd0);  // -675>>>6 = -11
    pix(320, 226, 12'hAF3, 1'b1, 3'd0);  // u=9 v=-10
    pix(320, 225, 12'hAAA, 1'b0, 3'd0);  // u=10 v=-11
    idle(6);

    // Circle, obj1 at (100,100) size 10 colour 123
    wr(1, 0, 16'd100, 1'b0);
    wr(1, 1, 16'd100, 1'b0);
    wr(1, 2, 16'd10, 1'b0);
    wr(1, 7, 16'hC123, 1'b0);
    commit();
    pix(107, 107, 12'h123, 1'b1, 3'd1);  // 98
    pix(108, 107, 12'hEEE, 1'b0, 3'd0);  // 113
    pix(110, 100, 12'h123, 1'b1, 3'd1);  // 100
    pix(90, 100, 12'h123, 1'b1, 3'd1);   // 100
    pix(100, 111, 12'hEEE, 1'b0, 3'd0);  // 121
    pix(320, 240, 12'hAF3, 1'b1, 3'd0);
    idle(6);

    // Priority: obj1 moved under obj0
    wr(1, 0, 16'd320, 1'b0);
    wr(1, 1, 16'd240, 1'b0);
    commit();
    pix(320, 240, 12'hAF3, 1'b1, 3'd0);
    idle(6);

    // Commit semantics
    wr(0, 0, 16'd500, 1'b0);
    pix(320, 240, 12'hAF3, 1'b1, 3'd0);
    pix(500, 240, 12'h888, 1'b0, 3'd0);
    wr(0, 0, 16'd400, 1'b1);
    pix(500, 240, 12'hAF3, 1'b1, 3'd0);
    pix(320, 240, 12'h123, 1'b1, 3'd1);
    pix(400, 240, 12'h999, 1'b0, 3'd0);
    commit();
    pix(400, 240, 12'hAF3, 1'b1, 3'd0);
    pix(500, 240, 12'h888, 1'b0, 3'd0);
    idle(6);

    // Streaming with one bubble (obj0 at 400, obj1 circle at 320)
    pix(380, 240, 12'hAAA, 1'b0, 3'd0);
    pix(386, 240, 12'hAF3, 1'b1, 3'd0);
    pix(385, 240, 12'h999, 1'b0, 3'd0);
    pix(415, 240, 12'hAF3, 1'b1, 3'd0);
    tick();
    pix(416, 240, 12'h999, 1'b0, 3'd0);
    pix(0, 240, 12'hFFF, 1'b0, 3'd0);
    pix(1023, 240, 12'h000, 1'b0, 3'd0);
    pix(325, 240, 12'h123, 1'b1, 3'd1);
    idle(6);

    // Reset mid-stream: three pixels in flight are discarded
    pix(386, 240, 12'hAF3, 1'b1, 3'd0);
    pix(400, 240, 12'hAF3, 1'b1, 3'd0);
    pix(415, 240, 12'hAF3, 1'b1, 3'd0);
    Reset = 1'b1;
    sb.delete();
    tick();
    @(negedge Clk);
    checks++;
    if ({out_valid, hit, hit_id, Red, Green, Blue} !== 20'h0) begin
      errors++;
      $display("FAIL midstream_reset: got %h, required 0", {out_valid, hit, hit_id, Red, Green, Blue});
    end
    tick();
    Reset = 1'b0;
    idle(6);
    // Registers cleared: no object any more
    pix(400, 240, 12'h999, 1'b0, 3'd0);
    idle(6);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: got %0d pending, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
